// File: rtl/seg7_pkg.sv
// Shared definitions for the two-digit 7-segment pair encoder and its decoder twin.
// Glyph bits are active-high, bit6..0 = a..g.
package seg7_pkg;

  localparam int SEG_W      = 7;
  localparam int DIGIT_W    = 4;
  localparam int VALUE_W    = 6;
  localparam int SUM_W      = 7;
  localparam int NUM_DIGITS = 10;
  localparam int MAX_VALUE  = 63;
  localparam int PAIR_W     = 2 * SEG_W;

  // Packed so that SEG7_DIGIT[d] is the glyph for digit d.
  localparam logic [NUM_DIGITS-1:0][SEG_W-1:0] SEG7_DIGIT = {
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_UNITS = 2'b01,
    ERR_TENS  = 2'b10,
    ERR_RANGE = 2'b11
  } err_code_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILTER  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_t;

  // Up to 99 for two decimal digits, so 7 bits hold it without wrap.
  function automatic logic [SUM_W-1:0] pair_sum(input logic [DIGIT_W-1:0] tens,
                                                input logic [DIGIT_W-1:0] units);
    return SUM_W'(tens) * SUM_W'(10) + SUM_W'(units);
  endfunction

endpackage

// File: rtl/seg7_glyph_to_digit.sv
// Combinational lookup of one active-high 7-segment glyph into its decimal digit.
// valid is low for any pattern that is not one of the ten digit glyphs.
module seg7_glyph_to_digit
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0]   glyph,
  output logic [DIGIT_W-1:0] digit,
  output logic               valid
);

  always_comb begin
    digit = '0;
    valid = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (glyph == SEG7_DIGIT[i]) begin
        digit = DIGIT_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_pair_encoder.sv
// Recovers the 6-bit count from an active-low tens/units segment pair once the pair
// has been seen STABLE_CYCLES times in a row; result leaves via valid/ready.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | waiting for the first sample; it becomes ref with cnt=1
// ST_FILTER  | counting consecutive matching samples against ref
// ST_CONVERT | one cycle: look up both glyphs of ref, register value/err_code
// ST_OUTPUT  | out_valid high, result held until out_ready
module seg7_pair_encoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SEG_W-1:0]   seg_units_n,
  input  logic [SEG_W-1:0]   seg_tens_n,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [VALUE_W-1:0] value,
  output logic [1:0]         err_code,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam logic [3:0] CNT_TARGET = 4'(STABLE_CYCLES);

  state_t              state, state_nxt;
  logic [PAIR_W-1:0]   ref_pair, ref_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                load_result;
  logic [PAIR_W-1:0]   sample;
  logic                accept;

  logic [DIGIT_W-1:0]  tens_digit, units_digit;
  logic                tens_ok, units_ok;
  logic [SUM_W-1:0]    sum;
  logic [VALUE_W-1:0]  conv_value;
  err_code_t           conv_err;

  assign sample   = {seg_tens_n, seg_units_n};
  assign in_ready = rst_n && ((state == ST_IDLE) || (state == ST_FILTER));
  assign accept   = in_valid && in_ready;

  seg7_glyph_to_digit u_tens (
    .glyph (~ref_pair[PAIR_W-1:SEG_W]),
    .digit (tens_digit),
    .valid (tens_ok)
  );

  seg7_glyph_to_digit u_units (
    .glyph (~ref_pair[SEG_W-1:0]),
    .digit (units_digit),
    .valid (units_ok)
  );

  assign sum = pair_sum(tens_digit, units_digit);

  // Tens glyph errors outrank units glyph errors, which outrank range.
  always_comb begin
    conv_value = '0;
    conv_err   = ERR_NONE;
    if (!tens_ok) begin
      conv_err = ERR_TENS;
    end else if (!units_ok) begin
      conv_err = ERR_UNITS;
    end else if (sum > SUM_W'(MAX_VALUE)) begin
      conv_err = ERR_RANGE;
    end else begin
      conv_value = sum[VALUE_W-1:0];
    end
  end

  always_comb begin
    state_nxt   = state;
    ref_nxt     = ref_pair;
    cnt_nxt     = cnt;
    load_result = 1'b0;
    out_valid   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          ref_nxt   = sample;
          cnt_nxt   = 4'd1;
          state_nxt = (STABLE_CYCLES == 1) ? ST_CONVERT : ST_FILTER;
        end
      end
      ST_FILTER: begin
        if (accept) begin
          if (sample == ref_pair) begin
            cnt_nxt = cnt + 4'd1;
            if (cnt + 4'd1 == CNT_TARGET) begin
              state_nxt = ST_CONVERT;
            end
          end else begin
            // A mismatch on what would have been the final sample still restarts.
            ref_nxt = sample;
            cnt_nxt = 4'd1;
          end
        end
      end
      ST_CONVERT: begin
        load_result = 1'b1;
        state_nxt   = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_nxt   = 4'd0;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ref_pair <= '0;
      cnt      <= 4'd0;
      value    <= '0;
      err_code <= ERR_NONE;
    end else begin
      state    <= state_nxt;
      ref_pair <= ref_nxt;
      cnt      <= cnt_nxt;
      if (load_result) begin
        value    <= conv_value;
        err_code <= conv_err;
      end
    end
  end

endmodule
